bcd_conv_scheduler: RTL and testbench

- Shares one iterative shift-add-3 binary-to-BCD engine between NUM_CH requesters, e.g. score, timer, level and high-score.
- Arbitrates round-robin and converts one bit per clock.
- Stores each channel's last result in a digit bank that the seven-segment display mux reads continuously.
- Replaces per-channel combinational converters, saving area in the memory-game top level.

---
 rtl/bcd_pkg.sv | 30 +++
 rtl/bcd_iter_core.sv | 56 +++++
 rtl/bcd_conv_scheduler.sv | 160 ++++++++++++++++
 tb/tb_bcd_conv_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : bcd_pkg                                                |
// | Shared constants, FSM state type and the add-3 nibble correction |
// | used by the shared binary-to-BCD conversion scheduler.           |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package bcd_pkg;

  localparam int BIN_W   = 8;
  localparam int DIGIT_W = 4;
  localparam int NDIG    = 3;
  localparam int BCD_W   = NDIG * DIGIT_W;
  localparam int SH_W    = BCD_W + BIN_W;

  localparam logic [DIGIT_W-1:0] BCD_BLANK = 4'hF;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Double-dabble correction: a digit of 5 or more would overflow past 9
  // after the next doubling, so pre-bias it by 3.
  function automatic logic [DIGIT_W-1:0] add3(input logic [DIGIT_W-1:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_iter_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : bcd_iter_core                                          |
// | Iterative shift-add-3 binary-to-BCD engine, one bit per clock.   |
// | start loads the operand; done is high during the cycle whose     |
// | closing edge performs the eighth shift, with result showing the  |
// | digits that edge produces.                                       |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module bcd_iter_core
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] result
);

  logic [SH_W-1:0] r_sh;
  logic [2:0]      r_cnt;
  logic            r_busy;
  logic [SH_W-1:0] w_corr;
  logic [SH_W-1:0] w_shifted;

  // Correct each BCD nibble, then shift the whole register left by one.
  always_comb begin
    w_corr    = {add3(r_sh[19:16]), add3(r_sh[15:12]), add3(r_sh[11:8]), r_sh[7:0]};
    w_shifted = {w_corr[SH_W-2:0], 1'b0};
  end

  assign done   = r_busy && (r_cnt == 3'd7);
  assign result = w_shifted[SH_W-1:BIN_W];

  // Load on start, otherwise step once per clock until eight shifts are done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh   <= '0;
      r_cnt  <= 3'd0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_sh   <= {{BCD_W{1'b0}}, bin};
      r_cnt  <= 3'd0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_sh  <= w_shifted;
      r_cnt <= r_cnt + 3'd1;
      if (r_cnt == 3'd7) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_conv_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : bcd_conv_scheduler                                     |
// | Round-robin scheduler sharing one iterative binary-to-BCD engine |
// | between NUM_CH requesters; keeps a per-channel digit bank that   |
// | the display mux reads continuously.                              |
// | Option  : BCD_LEADING_BLANK_EN - store leading zero digits as F. |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module bcd_conv_scheduler
  import bcd_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int BIN_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   req,
  input  logic [NUM_CH*8-1:0] bin_in,
  output logic                busy,
  output logic                done,
  output logic [2:0]          done_ch,
  output logic [NUM_CH*12-1:0] bcd_bank,
  output logic [NUM_CH-1:0]   bank_valid
);

  state_t            r_state;
  logic [NUM_CH-1:0] r_pending;
  logic [2:0]        r_rr_ptr;
  logic [2:0]        r_cur_ch;
  logic              r_busy;
  logic              r_done;
  logic [2:0]        r_done_ch;
  logic [NUM_CH-1:0] r_bank_valid;
  logic [BCD_W-1:0]  r_bank [NUM_CH];

  logic              w_any;
  logic [2:0]        w_gnt;
  logic [2:0]        w_rr_next;
  logic [NUM_CH-1:0] w_gnt_mask;
  logic              w_start;
  logic [7:0]        w_bin;
  logic              w_core_done;
  logic [BCD_W-1:0]  w_result;
  logic [BCD_W-1:0]  w_store;
  int                w_idx;

  // Find the first pending channel at or after rr_ptr, wrapping around.
  always_comb begin
    w_any = 1'b0;
    w_gnt = 3'd0;
    w_idx = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= NUM_CH) begin
        w_idx = w_idx - NUM_CH;
      end
      if (!w_any && r_pending[w_idx]) begin
        w_any = 1'b1;
        w_gnt = 3'(w_idx);
      end
    end
  end

  assign w_start   = (r_state == IDLE) && w_any;
  assign w_rr_next = (w_gnt == 3'(NUM_CH - 1)) ? 3'd0 : (w_gnt + 3'd1);

  // Decode the grant into a clear mask and select the granted operand.
  always_comb begin
    w_gnt_mask = '0;
    w_bin      = 8'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_gnt == 3'(c)) begin
        w_gnt_mask[c] = w_start;
        w_bin         = bin_in[c*8 +: 8];
      end
    end
  end

  bcd_iter_core u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_start),
    .bin    (w_bin),
    .done   (w_core_done),
    .result (w_result)
  );

  // Format the finished digits for the bank, blanking leading zeros if enabled.
  always_comb begin
    w_store = w_result;
`ifdef BCD_LEADING_BLANK_EN
    if (w_result[11:8] == 4'd0) begin
      w_store[11:8] = BCD_BLANK;
      if (w_result[7:4] == 4'd0) begin
        w_store[7:4] = BCD_BLANK;
      end
    end
`endif
  end

  // Pending latch, arbitration state machine and digit bank update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pending    <= '0;
      r_rr_ptr     <= 3'd0;
      r_cur_ch     <= 3'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_done_ch    <= 3'd0;
      r_bank_valid <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_bank[c] <= '0;
      end
    end else begin
      // A request arriving on the grant edge re-queues the channel.
      r_pending <= (r_pending & ~w_gnt_mask) | req;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_cur_ch <= w_gnt;
            r_rr_ptr <= w_rr_next;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_core_done) begin
            for (int c = 0; c < NUM_CH; c++) begin
              if (r_cur_ch == 3'(c)) begin
                r_bank[c]       <= w_store;
                r_bank_valid[c] <= 1'b1;
              end
            end
            r_done    <= 1'b1;
            r_done_ch <= r_cur_ch;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_bank_out
      assign bcd_bank[c*12 +: 12] = r_bank[c];
    end
  endgenerate

  assign busy       = r_busy;
  assign done       = r_done;
  assign done_ch    = r_done_ch;
  assign bank_valid = r_bank_valid;

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_bcd_conv_scheduler                                  |
// | Directed self-checking bench for bcd_conv_scheduler (4 channels).|
// | Expected digits follow BCD_LEADING_BLANK_EN when it is defined.  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_bcd_conv_scheduler;

  localparam int NUM_CH = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_CH-1:0]    req;
  logic [NUM_CH*8-1:0]  bin_in;
  logic                 busy;
  logic                 done;
  logic [2:0]           done_ch;
  logic [NUM_CH*12-1:0] bcd_bank;
  logic [NUM_CH-1:0]    bank_valid;

  int n_checks = 0;
  int n_err    = 0;
  int lat;
  logic seen_done;

  bcd_conv_scheduler #(.NUM_CH(NUM_CH), .BIN_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .done_ch    (done_ch),
    .bcd_bank   (bcd_bank),
    .bank_valid (bank_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen or the budget runs out; n is ticks taken.
  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < max);
  endtask

  task automatic set_bin(input int ch, input logic [7:0] v);
    bin_in[ch*8 +: 8] = v;
  endtask

  // Expected bank digits from decimal arithmetic.
  function automatic logic [11:0] exp_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
`ifdef BCD_LEADING_BLANK_EN
    if (h == 4'd0) begin
      h = 4'hF;
      if (t == 4'd0) t = 4'hF;
    end
`endif
    return {h, t, o};
  endfunction

  function automatic logic [11:0] bank_of(input int ch);
    return bcd_bank[ch*12 +: 12];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    bin_in = '0;
    tick();
    // Reset state
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_ch",    done_ch, 0);
    chk("rst_bank",  bcd_bank, 0);
    chk("rst_valid", bank_valid, 0);
    tick();
    rst_n = 1'b1;

    // Step 1: channel 0 converts 255 with a single-cycle request
    set_bin(0, 8'd255);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    chk("t1_busy_grant", busy, 1);
    wait_done(20, lat);
    chk("t1_latency", lat + 1, 9);
    chk("t1_done", done, 1);
    chk("t1_ch", done_ch, 0);
    chk("t1_bank0", bank_of(0), exp_bcd(255));
    chk("t1_valid", bank_valid, 4'b0001);
    chk("t1_busy_end", busy, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // Step 2: all channels at once, operands 0/9/99/200
    do_reset();
    set_bin(0, 8'd0);
    set_bin(1, 8'd9);
    set_bin(2, 8'd99);
    set_bin(3, 8'd200);
    req = 4'b1111;
    tick();
    req = 4'b0000;
    for (int c = 0; c < NUM_CH; c++) begin
      wait_done(20, lat);
      chk($sformatf("t2_lat%0d", c), lat, 9);
      chk($sformatf("t2_ch%0d", c), done_ch, c);
    end
    chk("t2_bank0", bank_of(0), exp_bcd(0));
    chk("t2_bank1", bank_of(1), exp_bcd(9));
    chk("t2_bank2", bank_of(2), exp_bcd(99));
    chk("t2_bank3", bank_of(3), exp_bcd(200));
    chk("t2_valid", bank_valid, 4'b1111);

    // Step 3: round-robin fairness after a grant to channel 1
    set_bin(1, 8'd17);
    req = 4'b0010;
    tick();
    req = 4'b0000;
    wait_done(20, lat);
    chk("t3_ch1", done_ch, 1);
    chk("t3_bank1", bank_of(1), exp_bcd(17));
    set_bin(0, 8'd64);
    set_bin(2, 8'd128);
    req = 4'b0101;
    tick();
    req = 4'b0000;
    wait_done(20, lat);
    chk("t3_first", done_ch, 2);
    chk("t3_bank2", bank_of(2), exp_bcd(128));
    wait_done(20, lat);
    chk("t3_second", done_ch, 0);
    chk("t3_lat_second", lat, 9);
    chk("t3_bank0", bank_of(0), exp_bcd(64));

    // Step 4: channel 3 re-requests during its own conversion
    set_bin(3, 8'd42);
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick();
    tick();
    tick();
    set_bin(3, 8'd43);
    req = 4'b1000;
    tick();
    req = 4'b0000;
    wait_done(20, lat);
    chk("t4_lat_first", lat, 5);
    chk("t4_ch_first", done_ch, 3);
    chk("t4_bank_first", bank_of(3), exp_bcd(42));
    chk("t4_others", bcd_bank[35:0], {exp_bcd(128), exp_bcd(17), exp_bcd(64)});
    wait_done(20, lat);
    chk("t4_lat_second", lat, 9);
    chk("t4_ch_second", done_ch, 3);
    chk("t4_bank_second", bank_of(3), exp_bcd(43));

    // Step 5: reset during the fourth shift cycle aborts the conversion
    set_bin(0, 8'd123);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    tick();
    tick();
    tick();
    chk("t5_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy_rst", busy, 0);
    chk("t5_done_rst", done, 0);
    chk("t5_bank_rst", bcd_bank, 0);
    chk("t5_valid_rst", bank_valid, 0);
    tick();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) seen_done = 1'b1;
    end
    chk("t5_quiet", seen_done, 0);
    set_bin(0, 8'd77);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    wait_done(20, lat);
    chk("t5_lat", lat, 9);
    chk("t5_bank", bcd_bank, {36'd0, exp_bcd(77)});
    chk("t5_valid", bank_valid, 4'b0001);

    // Step 6: blanking patterns on channel 2
    set_bin(2, 8'd7);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    wait_done(20, lat);
    chk("t6_7", bank_of(2), exp_bcd(7));
    set_bin(2, 8'd105);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    wait_done(20, lat);
    chk("t6_105", bank_of(2), exp_bcd(105));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
